// File: rtl/dcache_assoc_wb.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU, halt-triggered flush and hit/miss counters.
// Hits complete combinationally in IDLE; misses stall the datapath (dhit=0) while memory beats wait on dwait.
module dcache_assoc_wb #(
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int BLK_WORDS = 2,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halt,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic [31:0]      dmemaddr,
  input  logic [31:0]      dmemstore,
  output logic [31:0]      dmemload,
  output logic             dhit,
  output logic             flushed,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      dstore,
  input  logic [31:0]      dload,
  input  logic             dwait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int BOFF = $clog2(BLK_WORDS);
  localparam int BCW  = (BOFF > 0) ? BOFF : 1;
  localparam int IW   = $clog2(SETS);
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TW   = 30 - BOFF - IW;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH, S_FLUSHED} state_t;

  state_t           r_state, w_next;
  logic             r_valid [WAYS][SETS];
  logic             r_dirty [WAYS][SETS];
  logic [TW-1:0]    r_tag   [WAYS][SETS];
  logic [31:0]      r_data  [WAYS][SETS][BLK_WORDS];
  logic [WW-1:0]    r_age   [SETS][WAYS];
  logic [TW-1:0]    r_mtag;
  logic [IW-1:0]    r_midx, r_fset;
  logic [WW-1:0]    r_victim, r_fway;
  logic [BCW-1:0]   r_beat;
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

  logic [IW-1:0]    w_idx;
  logic [BCW-1:0]   w_blk;
  logic [TW-1:0]    w_tag;
  logic             w_req, w_hit, w_inv_found, w_last, w_fl_last, w_fl_dirty, w_fl_adv;
  logic [WW-1:0]    w_hway, w_hage, w_inv_way, w_lru_way, w_lru_age, w_vway;

  function automatic logic [31:0] f_addr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                         input logic [BCW-1:0] b);
    return (32'(t) << (2 + BOFF + IW)) | (32'(i) << (2 + BOFF)) | (32'(b) << 2);
  endfunction

  assign w_idx      = IW'(dmemaddr >> (2 + BOFF));
  assign w_blk      = BCW'((dmemaddr >> 2) & 32'(BLK_WORDS - 1));
  assign w_tag      = TW'(dmemaddr >> (2 + BOFF + IW));
  assign w_req      = dmemREN | dmemWEN;
  assign w_last     = (r_beat == BCW'(BLK_WORDS - 1));
  assign w_fl_last  = (r_fset == IW'(SETS - 1)) && (r_fway == WW'(WAYS - 1));
  assign w_fl_dirty = r_valid[r_fway][r_fset] && r_dirty[r_fway][r_fset];
  assign w_fl_adv   = (r_state == S_FLUSH) && (!w_fl_dirty || (!dwait && w_last));
  assign w_hage     = r_age[w_idx][w_hway];
  assign w_vway     = w_inv_found ? w_inv_way : w_lru_way;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  // Lookup plus victim choice: lowest invalid way first, otherwise the oldest way.
  always_comb begin
    w_hit       = 1'b0;
    w_hway      = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    w_lru_age   = r_age[w_idx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = WW'(w);
      end
      if (!w_inv_found && !r_valid[w][w_idx]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WW'(w);
      end
      if (r_age[w_idx][w] > w_lru_age) begin
        w_lru_age = r_age[w_idx][w];
        w_lru_way = WW'(w);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            dhit     = 1'b1;
            dmemload = r_data[w_hway][w_idx][w_blk];
          end else begin
            w_next = (r_valid[w_vway][w_idx] && r_dirty[w_vway][w_idx]) ? S_WB : S_FILL;
          end
        end else if (halt) begin
          w_next = S_FLUSH;
        end
      end
      S_WB: begin
        dWEN   = 1'b1;
        daddr  = f_addr(r_tag[r_victim][r_midx], r_midx, r_beat);
        dstore = r_data[r_victim][r_midx][r_beat];
        if (!dwait && w_last) w_next = S_FILL;
      end
      S_FILL: begin
        dREN  = 1'b1;
        daddr = f_addr(r_mtag, r_midx, r_beat);
        if (!dwait && w_last) w_next = halt ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (w_fl_dirty) begin
          dWEN   = 1'b1;
          daddr  = f_addr(r_tag[r_fway][r_fset], r_fset, r_beat);
          dstore = r_data[r_fway][r_fset][r_beat];
        end
        if (w_fl_adv && w_fl_last) w_next = S_FLUSHED;
      end
      S_FLUSHED: flushed = 1'b1;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
          r_age[s][w]   <= '0;
        end
      end
      r_mtag     <= '0;
      r_midx     <= '0;
      r_victim   <= '0;
      r_beat     <= '0;
      r_fset     <= '0;
      r_fway     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_fset <= '0;
          r_fway <= '0;
          r_beat <= '0;
          if (w_req && w_hit) begin
            // "<=" rather than "<" also separates the equal ages left behind by reset.
            for (int w = 0; w < WAYS; w++) begin
              if (WW'(w) == w_hway)
                r_age[w_idx][w] <= '0;
              else if (r_age[w_idx][w] <= w_hage && r_age[w_idx][w] != WW'(WAYS - 1))
                r_age[w_idx][w] <= r_age[w_idx][w] + WW'(1);
            end
            if (dmemWEN) r_dirty[w_hway][w_idx] <= 1'b1;
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
          end else if (w_req) begin
            r_mtag   <= w_tag;
            r_midx   <= w_idx;
            r_victim <= w_vway;
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
          end
        end
        S_WB: if (!dwait) r_beat <= w_last ? '0 : r_beat + BCW'(1);
        S_FILL: begin
          if (!dwait) begin
            r_beat <= w_last ? '0 : r_beat + BCW'(1);
            if (w_last) begin
              r_valid[r_victim][r_midx] <= 1'b1;
              r_dirty[r_victim][r_midx] <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (w_fl_dirty && !dwait) r_beat <= w_last ? '0 : r_beat + BCW'(1);
          if (w_fl_adv) begin
            r_dirty[r_fway][r_fset] <= 1'b0;
            if (r_fway == WW'(WAYS - 1)) begin
              r_fway <= '0;
              r_fset <= r_fset + IW'(1);
            end else begin
              r_fway <= r_fway + WW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (r_state == S_IDLE && w_req && w_hit && dmemWEN)
        r_data[w_hway][w_idx][w_blk] <= dmemstore;
      if (r_state == S_FILL && !dwait) begin
        r_data[r_victim][r_midx][r_beat] <= dload;
        if (w_last) r_tag[r_victim][r_midx] <= r_mtag;
      end
    end
  end
endmodule

// File: tb/tb_dcache_assoc_wb.sv
// Scoreboard bench for dcache_assoc_wb: directed requests push expected hits and memory beats; a monitor pops on each DUT event.
module tb_dcache_assoc_wb;
  localparam int K_HIT = 0, K_WHIT = 1, K_RD = 2, K_WR = 3;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] dat;
  } ev_t;

  ev_t q[$];
  int n_vec = 0;
  int n_err = 0;

  logic        CLK = 1'b0, RST = 1'b1, halt = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic [31:0] dmemload, daddr, dstore, dload;
  logic        dhit, flushed, dREN, dWEN;
  logic        dwait = 1'b1;
  logic [31:0] hit_count, miss_count;
  logic [31:0] mem [0:1023];

  dcache_assoc_wb dut (
    .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;
  assign dload = mem[daddr[11:2]];

  // Memory: every beat sees dwait=1 for two cycles, then completes.
  initial begin
    int          cnt;
    logic        req, we, dw;
    logic [31:0] a, d;
    cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
    forever begin
      @(negedge CLK);
      req = dREN | dWEN; we = dWEN; dw = dwait; a = daddr; d = dstore;
      @(posedge CLK); #1;
      if (req && !dw) begin
        if (we) mem[a[11:2]] = d;
        cnt = 0;
      end else if (req) cnt++;
      else cnt = 0;
      dwait = (cnt < 2);
    end
  end

  task automatic check_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event got kind=%0d addr=%h dat=%h, queue empty", kind, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.addr != a || (e.kind != K_WHIT && e.dat != d)) begin
        n_err++;
        $display("FAIL event got kind=%0d addr=%h dat=%h exp kind=%0d addr=%h dat=%h",
                 kind, a, d, e.kind, e.addr, e.dat);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (dREN && dWEN) begin
        n_err++;
        $display("FAIL rw_exclusive got dREN=1 dWEN=1 exp not both");
      end
      if (dhit) check_ev(dmemWEN ? K_WHIT : K_HIT, 32'h0, dmemWEN ? 32'h0 : dmemload);
      if ((dREN || dWEN) && !dwait) check_ev(dWEN ? K_WR : K_RD, daddr, dWEN ? dstore : 32'h0);
    end
  end

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.dat = d;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_req(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    dmemREN = re; dmemWEN = we; dmemaddr = a; dmemstore = d;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge CLK);
      got = dhit;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL req_timeout addr=%h got no dhit exp dhit", a);
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 60 && q.size() != 0; t++) begin
      @(posedge CLK); #1;
    end
    chk(name, 32'(q.size()), 32'h0);
  endtask

  task automatic wait_flushed();
    logic got;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge CLK);
      got = flushed;
    end
    chk("flushed_seen", {31'h0, got}, 32'h1);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_ctrl", {28'h0, dhit, dREN, dWEN, flushed}, 32'h0);
    chk("rst_daddr", daddr, 32'h0);
    chk("rst_dstore", dstore, 32'h0);
    chk("rst_dmemload", dmemload, 32'h0);
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
    @(posedge CLK); #1;

    // Cold read miss then hit.
    push(K_RD, 32'h40, 0); push(K_RD, 32'h44, 0); push(K_HIT, 0, 32'hC0DE_0040);
    do_req(1, 0, 32'h40, 0);
    wait_drain("cold_drain");
    chk("cold_miss_count", miss_count, 32'd1);
    chk("cold_hit_count", hit_count, 32'd1);

    // LRU: 0x80 is oldest when 0xC0 arrives.
    push(K_RD, 32'h80, 0); push(K_RD, 32'h84, 0); push(K_HIT, 0, 32'hC0DE_0080);
    do_req(1, 0, 32'h80, 0);
    push(K_HIT, 0, 32'hC0DE_0040);
    do_req(1, 0, 32'h40, 0);
    push(K_RD, 32'hC0, 0); push(K_RD, 32'hC4, 0); push(K_HIT, 0, 32'hC0DE_00C0);
    do_req(1, 0, 32'hC0, 0);
    push(K_HIT, 0, 32'hC0DE_0040);
    do_req(1, 0, 32'h40, 0);
    wait_drain("lru_drain");
    chk("lru_miss_count", miss_count, 32'd3);
    chk("lru_hit_count", hit_count, 32'd5);
    do_reset();

    // Write-allocate then dirty eviction.
    push(K_RD, 32'h40, 0); push(K_RD, 32'h44, 0); push(K_WHIT, 0, 0);
    do_req(0, 1, 32'h44, 32'hDEAD_BEEF);
    push(K_RD, 32'h80, 0); push(K_RD, 32'h84, 0); push(K_HIT, 0, 32'hC0DE_0084);
    do_req(1, 0, 32'h84, 0);
    push(K_WR, 32'h40, 32'hC0DE_0040); push(K_WR, 32'h44, 32'hDEAD_BEEF);
    push(K_RD, 32'hC0, 0); push(K_RD, 32'hC4, 0); push(K_HIT, 0, 32'hC0DE_00C4);
    do_req(1, 0, 32'hC4, 0);
    wait_drain("evict_drain");

    // Both enables high acts as a write; flush shows the line became dirty.
    push(K_RD, 32'h48, 0); push(K_RD, 32'h4C, 0); push(K_HIT, 0, 32'hC0DE_0048);
    do_req(1, 0, 32'h48, 0);
    push(K_WHIT, 0, 0);
    do_req(1, 1, 32'h48, 32'h1234_5678);
    push(K_HIT, 0, 32'h1234_5678);
    do_req(1, 0, 32'h48, 0);
    push(K_WR, 32'h48, 32'h1234_5678); push(K_WR, 32'h4C, 32'hC0DE_004C);
    halt = 1'b1;
    wait_flushed();
    wait_drain("both_flush_drain");
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("flushed_held", {28'h0, flushed, dREN, dWEN, dhit}, 32'h8);
    @(posedge CLK); #1;
    do_reset();

    // Flush of two dirty lines in different sets.
    push(K_RD, 32'h40, 0); push(K_RD, 32'h44, 0); push(K_WHIT, 0, 0);
    do_req(0, 1, 32'h40, 32'h1111_1111);
    push(K_RD, 32'h108, 0); push(K_RD, 32'h10C, 0); push(K_WHIT, 0, 0);
    do_req(0, 1, 32'h108, 32'h2222_2222);
    push(K_WR, 32'h40, 32'h1111_1111); push(K_WR, 32'h44, 32'hDEAD_BEEF);
    push(K_WR, 32'h108, 32'h2222_2222); push(K_WR, 32'h10C, 32'hC0DE_010C);
    halt = 1'b1;
    wait_flushed();
    wait_drain("flush_drain");
    chk("flush_hit_count", hit_count, 32'd2);
    chk("flush_miss_count", miss_count, 32'd2);
    do_reset();

    // halt raised during an in-flight fill, request withdrawn.
    begin
      logic seen;
      seen = 1'b0;
      push(K_RD, 32'h80, 0); push(K_RD, 32'h84, 0);
      dmemREN = 1'b1; dmemaddr = 32'h80;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge CLK);
        seen = dREN;
      end
      chk("halt_fill_started", {31'h0, seen}, 32'h1);
      @(posedge CLK); #1;
      halt = 1'b1; dmemREN = 1'b0;
      wait_flushed();
      wait_drain("halt_fill_drain");
      chk("halt_fill_miss", miss_count, 32'd1);
      chk("halt_fill_hit", hit_count, 32'd0);
    end
    do_reset();

    // Reset in the middle of a write-back.
    push(K_RD, 32'h40, 0); push(K_RD, 32'h44, 0); push(K_WHIT, 0, 0);
    do_req(0, 1, 32'h40, 32'h0000_AAAA);
    push(K_RD, 32'h80, 0); push(K_RD, 32'h84, 0); push(K_HIT, 0, 32'hC0DE_0080);
    do_req(1, 0, 32'h80, 0);
    push(K_WR, 32'h40, 32'h0000_AAAA);
    dmemREN = 1'b1; dmemaddr = 32'hC0;
    wait_drain("wb_beat0");
    RST = 1'b1; dmemREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_mem_req", {30'h0, dREN, dWEN}, 32'h0);
    chk("abort_hit_count", hit_count, 32'h0);
    chk("abort_miss_count", miss_count, 32'h0);
    @(posedge CLK); #1;
    push(K_RD, 32'h40, 0); push(K_RD, 32'h44, 0); push(K_HIT, 0, 32'h0000_AAAA);
    do_req(1, 0, 32'h40, 0);
    wait_drain("abort_refill_drain");
    chk("abort_refill_miss", miss_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_assoc_wb.md
Name: dcache_assoc_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the datapath and the memory arbiter.
- Successor to the fixed 2-way/8-set/2-word dcache. Adds configurable ways, sets and block size, true-LRU replacement with invalid-way priority, and a latched miss address.
- Also adds a halt-triggered flush of all dirty lines, with flushed handshake and hit/miss counters.

Parameters:
- WAYS, 2: associativity; power of two, 1..8.
- SETS, 8: sets per way; power of two, >=2.
- BLK_WORDS, 2: 32-bit words per block; power of two, >=1.
- CNT_W, 32: width of hit/miss counters.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high. One clock (CLK), no other reset.
- halt  in  1  datapath halted; request flush.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- dmemaddr  in  32  byte address (bits[1:0] ignored).
- dmemstore  in  32  write data.
- dmemload  out  32  read data, valid when dhit.
- dhit  out  1  request completed this cycle.
- flushed  out  1  all dirty lines written back.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data.
- dwait  in  1  memory busy; a beat completes on a cycle with the request high and dwait=0.
- hit_count  out  CNT_W  saturating count of dhit cycles.
- miss_count  out  CNT_W  saturating count of misses detected.

Behaviour:
- Address fields: bytoff [1:0]; blkoff next log2(BLK_WORDS) bits; idx next log2(SETS) bits; tag = remaining upper bits.
- Frame contents: valid, dirty, tag, BLK_WORDS words. Per set, one age field of log2(WAYS) bits per way; 0 = MRU.
- Reset (RST high at edge):
  - All valid, dirty, age, counters and word counter clear; state=IDLE.
  - Outputs: dhit=0, dREN=0, dWEN=0, flushed=0, daddr=0, dstore=0, dmemload=0.
  - Reset mid-miss or mid-flush aborts immediately.
- Request priority: dmemWEN has priority over dmemREN when both are high.
- IDLE hit: combinational, zero latency.
  - dhit=1 same cycle. Read drives dmemload from the matching way; write updates the word and sets dirty at the edge.
  - Touch: matching way age becomes 0; ways younger than it age by 1.
  - hit_count increments.
- IDLE miss:
  - Latch the block-aligned address and the victim way; miss_count increments.
  - Victim = lowest-index invalid way, else the way with age WAYS-1.
  - Victim dirty -> WB; else -> FILL.
  - dhit=0 throughout the miss.
- WB:
  - dWEN=1, daddr={victim tag, idx, beat, 00}, dstore=victim word[beat]; beat counts 0..BLK_WORDS-1.
  - Beat advances on dwait=0; after the last beat -> FILL.
- FILL:
  - dREN=1, daddr=latched block base + 4*beat; dload is captured into the victim word[beat] on dwait=0.
  - After the last beat: tag written, valid=1, dirty=0 -> IDLE.
  - The request then hits in IDLE on the following cycle, minimum 1 cycle after the last beat. A write merges at that hit.
- Request withdrawn or address changed mid-miss: the miss completes into the latched address; no abort, no dhit until a matching request is present in IDLE.
- halt in IDLE, no request pending: -> FLUSH.
  - Scan set by set, way by way; each dirty valid line is written back exactly like WB, then dirty is cleared.
  - Clean or invalid lines skip in 1 cycle.
- halt raised during a miss: the miss completes first, then FLUSH.
- After the last line -> FLUSHED: flushed=1 held until RST; no further memory requests; dhit=0.
- dREN and dWEN are never both high.
- daddr is stable while dwait is high.
- Counters saturate at all-ones.

Test Plan:
- Cold read 0x40, dwait=1 for 2 cycles per beat (defaults):
  - dREN at daddr 0x40 then 0x44, each held until dwait drops, no dWEN.
  - dhit the cycle after the fill completes with dmemload=mem[0x40]; miss_count=1, hit_count=1.
- Read 0x40, 0x80, 0x40, then read 0xC0 (all idx 0):
  - Victim is the way holding 0x80 (LRU).
  - A subsequent read of 0x40 hits with no memory traffic.
- Write 0x44=0xDEADBEEF (miss, allocate), then fill idx 0 via reads 0x84, 0xC4:
  - Eviction of 0x40 block issues dWEN at 0x40 with old mem data, then 0x44 with 0xDEADBEEF, before dREN at 0xC0.
- dmemREN and dmemWEN both high, address 0x48, on a hit:
  - Treated as a write; word updated, dirty=1.
- Write hits to 0x40 and 0x108, then halt=1:
  - Exactly 4 dWEN beats (0x40, 0x44, 0x108, 0x10C), then flushed=1 held.
  - halt during an in-flight fill: fill finishes, then flush.
- RST asserted mid-WB (after beat 0):
  - Next cycle dWEN=0, all lines invalid, counters=0.
  - A read of 0x40 misses and fills cleanly.
